// File: rtl/gcd_pkg.sv
// Shared types for the GCD engine: controller states and the runtime algorithm select.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } gcd_state_e;

  typedef enum logic {
    MODE_SUB,
    MODE_BIN
  } gcd_mode_e;

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD iteration: subtractive Euclid or binary (Stein) step on the operand pair.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] reg_x,
  input  logic [WIDTH-1:0] reg_y,
  input  gcd_mode_e        mode,
  output logic [WIDTH-1:0] next_x,
  output logic [WIDTH-1:0] next_y,
  output logic             inc_k,
  output logic             equal
);

  logic x_lt_y;
  logic x_even;
  logic y_even;

  assign x_lt_y = reg_x < reg_y;
  assign x_even = ~reg_x[0];
  assign y_even = ~reg_y[0];
  assign equal  = reg_x == reg_y;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can infer a latch.
    next_x = reg_x;
    next_y = reg_y;
    inc_k  = 1'b0;
    if (mode == MODE_SUB) begin
      if (x_lt_y) next_y = reg_y - reg_x;
      else        next_x = reg_x - reg_y;
    end else begin
      // Priority order matters: a shared factor of two is pulled out before any lone halving.
      if (x_even && y_even) begin
        next_x = reg_x >> 1;
        next_y = reg_y >> 1;
        inc_k  = 1'b1;
      end else if (x_even) begin
        next_x = reg_x >> 1;
      end else if (y_even) begin
        next_y = reg_y >> 1;
      end else if (x_lt_y) begin
        next_y = reg_y - reg_x;
      end else begin
        next_x = reg_x - reg_y;
      end
    end
  end

endmodule

// File: rtl/gcd_unit.sv
// GCD engine top: IDLE/CALC/DONE controller, operand registers and valid/ready handshakes.
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] cycles
);

  localparam int K_W = $clog2(WIDTH) + 1;

  gcd_state_e       state;
  gcd_state_e       state_next;
  gcd_mode_e        mode_r;
  logic [WIDTH-1:0] reg_x;
  logic [WIDTH-1:0] reg_y;
  logic [K_W-1:0]   k;
  logic [WIDTH-1:0] next_x;
  logic [WIDTH-1:0] next_y;
  logic             inc_k;
  logic             equal;
  logic             accept;
  logic             zero_op;

  gcd_step #(.WIDTH(WIDTH)) u_step (
    .reg_x  (reg_x),
    .reg_y  (reg_y),
    .mode   (mode_r),
    .next_x (next_x),
    .next_y (next_y),
    .inc_k  (inc_k),
    .equal  (equal)
  );

  assign accept  = in_valid && in_ready;
  assign zero_op = (x == '0) || (y == '0);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = zero_op ? DONE : CALC;
      end
      CALC: begin
        if (equal) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the datapath is a handful of flops, not a memory, so clearing it in reset is cheap and wanted.
    if (!rst) begin
      reg_x  <= '0;
      reg_y  <= '0;
      k      <= '0;
      mode_r <= MODE_SUB;
      result <= '0;
      cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            reg_x  <= x;
            reg_y  <= y;
            mode_r <= gcd_mode_e'(mode);
            k      <= '0;
            cycles <= '0;
            if (zero_op) result <= x | y;
          end
        end
        CALC: begin
          if (cycles != {CNT_W{1'b1}}) cycles <= cycles + 1'b1;
          // The terminating compare cycle is counted too; the shift restores the common power of two.
          if (equal) begin
            result <= reg_x << k;
          end else begin
            reg_x <= next_x;
            reg_y <= next_y;
            if (inc_k) k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
